// File: rtl/alu_pkg.sv
// Shared types and widths for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_SLL = 4'b0000,
        ALU_SRL = 4'b0001,
        ALU_SRA = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_AND = 4'b0101,
        ALU_OR  = 4'b0110,
        ALU_XOR = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_EQ  = 4'b1001,
        ALU_NE  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

endpackage

// File: rtl/core_alu_if.sv
// Issue/result bus between the execute stage and the ALU.
//   master: drives in_valid, alu_op, op1, op2; receives alu_result, out_valid
//   slave : the ALU side
interface core_alu_if
    import alu_pkg::*;
();
    logic            in_valid;
    alu_op_e         alu_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_result;
    logic            out_valid;

    modport master (
        output in_valid, alu_op, op1, op2,
        input  alu_result, out_valid
    );

    modport slave (
        input  in_valid, alu_op, op1, op2,
        output alu_result, out_valid
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter.
//   data_c  : value to shift
//   shamt_c : shift amount
//   mode_c  : SLL (zero fill), SRL (zero fill), SRA (sign fill)
//   res_c   : shifted value
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    data_c,
    input  logic [SHAMT_W-1:0] shamt_c,
    input  shift_mode_e        mode_c,
    output logic [XLEN-1:0]    res_c
);

    always_comb begin
        res_c = '0;
        case (mode_c)
            SH_SLL:  res_c = data_c << shamt_c;
            SH_SRL:  res_c = data_c >> shamt_c;
            SH_SRA:  res_c = XLEN'($signed(data_c) >>> shamt_c);
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/core_alu.sv
// Registered 32-bit integer ALU, one-cycle latency, full throughput.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : core_alu_if.slave (in_valid/alu_op/op1/op2 in, alu_result/out_valid out)
module core_alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    core_alu_if.slave   bus
);

    logic [XLEN-1:0] shift_res_c;
    logic [XLEN-1:0] result_c;
    shift_mode_e     shift_mode_c;
    logic [XLEN-1:0] result_q;
    logic            valid_q;

    // Shift direction from opcode; non-shift opcodes simply ignore the shifter output.
    always_comb begin
        shift_mode_c = SH_SRA;
        case (bus.alu_op)
            ALU_SLL: shift_mode_c = SH_SLL;
            ALU_SRL: shift_mode_c = SH_SRL;
            default: shift_mode_c = SH_SRA;
        endcase
    end

    alu_shifter u_shifter (
        .data_c  (bus.op1),
        .shamt_c (bus.op2[SHAMT_W-1:0]),
        .mode_c  (shift_mode_c),
        .res_c   (shift_res_c)
    );

    // Result select; reserved opcodes fall to the default arm and yield zero.
    always_comb begin
        result_c = '0;
        case (bus.alu_op)
            ALU_SLL, ALU_SRL, ALU_SRA: result_c = shift_res_c;
            ALU_ADD: result_c = bus.op1 + bus.op2;
            ALU_SUB: result_c = bus.op1 - bus.op2;
            ALU_AND: result_c = bus.op1 & bus.op2;
            ALU_OR:  result_c = bus.op1 | bus.op2;
            ALU_XOR: result_c = bus.op1 ^ bus.op2;
            ALU_SLT: result_c = XLEN'($signed(bus.op1) < $signed(bus.op2));
            ALU_EQ:  result_c = XLEN'(bus.op1 == bus.op2);
            ALU_NE:  result_c = XLEN'(bus.op1 != bus.op2);
            default: result_c = '0;
        endcase
    end

    // Output register; an idle cycle drops out_valid but keeps the last result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_c;
            end
        end
    end

    assign bus.alu_result = result_q;
    assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_core_alu.sv
// Self-checking bench for core_alu: directed literals, back-to-back/bubble,
// mid-cycle reset, and randomized traffic against a reference model.
module tb_core_alu;
    import alu_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    core_alu_if bus ();

    core_alu dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shifts via powers of two, compare via sign-bias.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] pw;
        logic [31:0] r;
        pw = 64'd1;
        for (int k = 0; k < int'(b[4:0]); k++) pw = pw * 64'd2;
        r = 32'h0;
        case (op)
            4'd0:  r = 32'({32'h0, a} * pw);
            4'd1:  r = 32'({32'h0, a} / pw);
            4'd2:  r = a[31] ? ~(32'({32'h0, ~a} / pw)) : 32'({32'h0, a} / pw);
            4'd3:  r = a + b;
            4'd4:  r = a - b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'h1 : 32'h0;
            4'd9:  r = (a == b) ? 32'h1 : 32'h0;
            4'd10: r = (a != b) ? 32'h1 : 32'h0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model of the registered outputs, tracking the same clock and reset.
    logic        m_valid;
    logic [31:0] m_result;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid  <= 1'b0;
            m_result <= 32'h0;
        end else begin
            m_valid <= bus.in_valid;
            if (bus.in_valid) m_result <= ref_alu(4'(bus.alu_op), bus.op1, bus.op2);
        end
    end

    // Continuous compare on the falling edge, away from the capture edge.
    always @(negedge clk) begin
        if (rstn) begin
            chk("cyc_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("cyc_result", bus.alu_result, m_result);
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = alu_op_e'(op);
        bus.op1      = a;
        bus.op2      = b;
    endtask

    // Issue one op, check its result one cycle later, then go idle.
    task automatic run_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        chk({name, "_model"}, ref_alu(op, a, b), exp);
        @(negedge clk);
        drive(op, a, b);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'h1);
        chk(name, bus.alu_result, exp);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0]  b2b_op  [4];
    logic [31:0] b2b_a   [4];
    logic [31:0] b2b_b   [4];
    logic [31:0] b2b_exp [4];
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bus.in_valid = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.op1      = 32'h0;
        bus.op2      = 32'h0;
        #3;
        chk("reset_result", bus.alu_result, 32'h0);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        #1 rstn = 1'b1;

        run_lit("sll",       4'd0,  32'h00010100, 32'h1, 32'h00020200);
        run_lit("srl",       4'd1,  32'h80010100, 32'h1, 32'h40008080);
        run_lit("sra",       4'd2,  32'h80010100, 32'h1, 32'hC0008080);
        run_lit("sll_sh0",   4'd0,  32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF);
        run_lit("sra_sh0",   4'd2,  32'h80000001, 32'h0, 32'h80000001);
        run_lit("sra_sh31",  4'd2,  32'h80000000, 32'h1F, 32'hFFFFFFFF);
        run_lit("srl_sh31",  4'd1,  32'h80000000, 32'h1F, 32'h00000001);
        run_lit("add",       4'd3,  32'h101, 32'h1, 32'h102);
        run_lit("sub",       4'd4,  32'h101, 32'h1, 32'h100);
        run_lit("and",       4'd5,  32'h101, 32'h1, 32'h1);
        run_lit("xor",       4'd7,  32'h101, 32'h1, 32'h100);
        run_lit("or",        4'd6,  32'h101, 32'h11100001, 32'h11100101);
        run_lit("add_wrap",  4'd3,  32'hFFFFFFFF, 32'h1, 32'h0);
        run_lit("sub_wrap",  4'd4,  32'h0, 32'h1, 32'hFFFFFFFF);
        run_lit("slt_a",     4'd8,  32'h101, 32'h1, 32'h0);
        run_lit("slt_neg",   4'd8,  32'h101, 32'h81000001, 32'h0);
        run_lit("slt_b",     4'd8,  32'h101, 32'h00110001, 32'h1);
        run_lit("slt_min",   4'd8,  32'h80000000, 32'h7FFFFFFF, 32'h1);
        run_lit("slt_eq",    4'd8,  32'h5, 32'h5, 32'h0);
        run_lit("eq_ne",     4'd9,  32'h101, 32'h1, 32'h0);
        run_lit("eq_eq",     4'd9,  32'h101, 32'h101, 32'h1);
        run_lit("ne",        4'd10, 32'h101, 32'h1, 32'h1);
        run_lit("rsv_f",     4'd15, 32'h101, 32'h1, 32'h0);
        run_lit("rsv_b",     4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);

        // Back-to-back issue then a one-cycle bubble.
        b2b_op[0] = 4'd3; b2b_a[0] = 32'h1;   b2b_b[0] = 32'h2; b2b_exp[0] = 32'h3;
        b2b_op[1] = 4'd7; b2b_a[1] = 32'hF;   b2b_b[1] = 32'h3; b2b_exp[1] = 32'hC;
        b2b_op[2] = 4'd0; b2b_a[2] = 32'h1;   b2b_b[2] = 32'h4; b2b_exp[2] = 32'h10;
        b2b_op[3] = 4'd6; b2b_a[3] = 32'h100; b2b_b[3] = 32'h1; b2b_exp[3] = 32'h101;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                chk($sformatf("b2b_valid%0d", i - 1), 32'(bus.out_valid), 32'h1);
                chk($sformatf("b2b_res%0d", i - 1), bus.alu_result, b2b_exp[i-1]);
            end
            if (i == 5) begin
                chk("bubble_valid", 32'(bus.out_valid), 32'h0);
                chk("bubble_hold", bus.alu_result, b2b_exp[3]);
            end
            if (i < 4) drive(b2b_op[i], b2b_a[i], b2b_b[i]);
            else       bus.in_valid = 1'b0;
        end

        // Asynchronous reset while a result is valid.
        @(negedge clk);
        drive(4'd3, 32'h2, 32'h3);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("async_rst_result", bus.alu_result, 32'h0);
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus.out_valid), 32'h0);
        run_lit("post_rst_add", 4'd3, 32'h7, 32'h8, 32'hF);

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            drive(4'($urandom_range(0, 15)), ra, rb);
            bus.in_valid = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
